pwm8_led_driver: RTL and testbench

- Downstream stage of the 8-channel LED brightness sequencer.
- Consumes the sequencer's 24-bit packed bus of eight 3-bit brightness codes (0 = dark, 1..4 = brightness steps) and drives eight LED pins with per-channel PWM.
- Double-buffers the codes so a new pattern takes effect only at a PWM period boundary; no glitches mid-period.
- Emits a frame pulse that the sequencer uses to advance its pattern.

---
 rtl/pwm8_led_driver.sv | 75 +++++++
 tb/tb_pwm8_led_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm8_led_driver.sv
// Eight-channel PWM LED driver: double-buffered brightness codes, 16-slice
// PWM period built from a prescaler, and a frame pulse at each period start.
module pwm8_led_driver #(
  parameter int N_CH     = 8,
  parameter int CODE_W   = 3,
  parameter int PRESCALE = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iEn,
  input  logic [N_CH*CODE_W-1:0]   iLevel,
  input  logic                     iLoad,
  output logic [N_CH-1:0]          oLed,
  output logic                     oFrame,
  output logic                     oPending
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0]              pre_cnt;
  logic [3:0]               slc;
  logic [N_CH*CODE_W-1:0]   shadow;
  logic [N_CH*CODE_W-1:0]   active;
  logic                     tick;
  logic                     boundary;
  logic [N_CH-1:0]          led_next;

  assign tick     = (pre_cnt == PRE_MAX) && iEn;
  assign boundary = tick && (slc == 4'd15);

  // Slices lit per 16-slice period; codes above 4 saturate at full on.
  function automatic logic [4:0] duty(input logic [CODE_W-1:0] code);
    logic [4:0] d;
    case (code)
      CODE_W'(0): d = 5'd0;
      CODE_W'(1): d = 5'd2;
      CODE_W'(2): d = 5'd4;
      CODE_W'(3): d = 5'd8;
      default:    d = 5'd16;
    endcase
    return d;
  endfunction

  always_comb begin
    led_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      led_next[i] = iEn && ({1'b0, slc} < duty(active[i*CODE_W +: CODE_W]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt  <= '0;
      slc      <= '0;
      shadow   <= '0;
      active   <= '0;
      oLed     <= '0;
      oFrame   <= 1'b0;
      oPending <= 1'b0;
    end else begin
      // Counters freeze while disabled and resume from where they stopped.
      if (iEn) begin
        pre_cnt <= (pre_cnt == PRE_MAX) ? 16'd0 : pre_cnt + 16'd1;
        if (tick) slc <= (slc == 4'd15) ? 4'd0 : slc + 4'd1;
      end
      // On a boundary the old shadow is applied; a same-cycle load waits.
      if (boundary) active <= shadow;
      if (iLoad)    shadow <= iLevel;
      oPending <= iLoad | (oPending & ~boundary);
      oLed     <= led_next;
      oFrame   <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm8_led_driver.sv
// Directed bench for pwm8_led_driver (PRESCALE=1) with a cycle model feeding
// an expected-output queue, plus per-channel duty counts over whole periods.
module tb_pwm8_led_driver;

  localparam int TB_PRE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iEn = 1'b0;
  logic [23:0] iLevel = '0;
  logic        iLoad = 1'b0;
  logic [7:0]  oLed;
  logic        oFrame;
  logic        oPending;

  pwm8_led_driver #(.N_CH(8), .CODE_W(3), .PRESCALE(TB_PRE)) dut (
    .clk(clk), .rst(rst), .iEn(iEn), .iLevel(iLevel), .iLoad(iLoad),
    .oLed(oLed), .oFrame(oFrame), .oPending(oPending)
  );

  always #5 clk = ~clk;

  // Scoreboard: {oLed, oFrame, oPending}
  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_pre = 0;
  int          m_slc = 0;
  logic [23:0] m_shadow = '0;
  logic [23:0] m_active = '0;
  logic        m_pend = 1'b0;
  int          duty_tab[8] = '{0, 2, 4, 8, 16, 16, 16, 16};

  logic [7:0] l_led;
  logic       l_frame;
  logic       l_pend;
  int         cnt[8];
  int         exp_cnt[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic en, input logic ld, input logic [23:0] lvl,
                            input logic rs, output logic [9:0] e);
    logic       tick, bnd;
    logic [7:0] led;
    if (!rs) begin
      m_pre = 0; m_slc = 0; m_shadow = '0; m_active = '0; m_pend = 1'b0;
      e = '0;
    end else begin
      tick = en && (m_pre == TB_PRE - 1);
      bnd  = tick && (m_slc == 15);
      for (int i = 0; i < 8; i++) begin
        int code;
        code = int'(m_active[i*3 +: 3]);
        led[i] = en && (m_slc < duty_tab[code]);
      end
      e = {led, bnd, (ld ? 1'b1 : (bnd ? 1'b0 : m_pend))};
      m_pend = e[0];
      if (bnd) m_active = m_shadow;
      if (ld)  m_shadow = lvl;
      if (en) begin
        m_pre = (m_pre == TB_PRE - 1) ? 0 : m_pre + 1;
        if (tick) m_slc = (m_slc == 15) ? 0 : m_slc + 1;
      end
    end
  endtask

  task automatic step(input logic en, input logic ld, input logic [23:0] lvl, input logic rs);
    logic [9:0] e, obs;
    rst = rs; iEn = en; iLoad = ld; iLevel = lvl;
    model_edge(en, ld, lvl, rs, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs = {oLed, oFrame, oPending};
    check("cycle", 32'(obs), 32'(exp_q.pop_front()));
    l_led = oLed; l_frame = oFrame; l_pend = oPending;
    iLoad = 1'b0;
  endtask

  // Steps until a frame pulse is observed; returns max+1 if none arrives.
  task automatic run_to_frame(input int max, output int n);
    n = max + 1;
    for (int k = 1; k <= max; k++) begin
      step(1'b1, 1'b0, 24'h0, 1'b1);
      if (l_frame) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic count_period();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 24'h0, 1'b1);
      for (int i = 0; i < 8; i++) if (l_led[i]) cnt[i]++;
    end
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 8; i++) check(tag, 32'(cnt[i]), 32'(exp_cnt[i]));
  endtask

  task automatic set_exp(input int a, input int b, input int c, input int d,
                         input int e4, input int f, input int g, input int h);
    exp_cnt = '{a, b, c, d, e4, f, g, h};
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset state
    step(1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    check("reset_led", 32'(l_led), 32'h0);
    check("reset_pend", 32'(l_pend), 32'h0);

    // 1: idle run, first frame on 16th enabled cycle
    run_to_frame(40, n);
    check("first_frame", 32'(n), 32'd16);
    check("idle_pend", 32'(l_pend), 32'h0);
    run_to_frame(40, n);
    check("frame_period", 32'(n), 32'd16);

    // 2: load codes {1,2,3,4} into ch3..ch0
    step(1'b1, 1'b1, 24'h00029C, 1'b1);
    check("load_pend", 32'(l_pend), 32'h1);
    run_to_frame(40, n);
    check("load_frame", 32'(n), 32'd15);
    check("load_pend_clear", 32'(l_pend), 32'h0);
    count_period();
    set_exp(16, 8, 4, 2, 0, 0, 0, 0);
    check_counts("duty_1234");

    // 3: load on the exact boundary cycle
    step(1'b1, 1'b1, 24'h249249, 1'b1);
    while (m_slc != 15) step(1'b1, 1'b0, 24'h0, 1'b1);
    step(1'b1, 1'b1, 24'h924924, 1'b1);
    check("bnd_frame", 32'(l_frame), 32'h1);
    check("bnd_pend", 32'(l_pend), 32'h1);
    count_period();
    set_exp(2, 2, 2, 2, 2, 2, 2, 2);
    check_counts("bnd_old");
    check("bnd_pend_clear", 32'(l_pend), 32'h0);
    count_period();
    set_exp(16, 16, 16, 16, 16, 16, 16, 16);
    check_counts("bnd_new");

    // 4: codes 5,6,7 clamp like code 4
    step(1'b1, 1'b1, 24'h0009F5, 1'b1);
    run_to_frame(40, n);
    count_period();
    set_exp(16, 16, 16, 16, 0, 0, 0, 0);
    check_counts("clamp");

    // 5: enable gap at slc=7
    while (m_slc != 7) step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 24'h0, 1'b1);
      check("gap_led", 32'(l_led), 32'h0);
      check("gap_frame", 32'(l_frame), 32'h0);
    end
    run_to_frame(40, n);
    check("resume_frame", 32'(n), 32'd9);

    // 6: reset mid-period with a pending load
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 24'h0, 1'b1);
    step(1'b1, 1'b1, 24'h249249, 1'b1);
    step(1'b1, 1'b0, 24'h0, 1'b1);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    check("rst_led", 32'(l_led), 32'h0);
    check("rst_pend", 32'(l_pend), 32'h0);
    run_to_frame(40, n);
    check("rst_slc0", 32'(n), 32'd16);
    count_period();
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    check_counts("rst_dark");
    step(1'b1, 1'b1, 24'h249249, 1'b1);
    run_to_frame(40, n);
    count_period();
    set_exp(2, 2, 2, 2, 2, 2, 2, 2);
    check_counts("rst_reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
